sa_result_uart_framer: RTL and testbench

Downstream drain stage for the systolic MAC array: accepts signed 32-bit accumulator results over a valid/ready port, buffers them in a small FIFO, and serializes each result into a fixed 7-byte frame for the transmit-only 8N1 UART (`uart_tx_8n1`). It replaces the single-byte "send low byte at cycle 40" path, so full-width results and result ordering survive the serial link.

---
 rtl/sa_result_uart_framer.sv | 116 +++++++++++
 tb/tb_sa_result_uart_framer.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/sa_result_uart_framer.sv
// sa_result_uart_framer: buffers 32-bit results in a FIFO and frames each into 7 bytes for an 8N1 UART
module sa_result_uart_framer #(
    parameter int         FIFO_DEPTH = 4,
    parameter logic [7:0] SYNC_BYTE  = 8'hA5
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        res_valid,
    input  logic [31:0] res_data,
    output logic        res_ready,
    output logic [7:0]  tx_byte,
    output logic        tx_send,
    input  logic        tx_done,
    output logic        busy,
    output logic [7:0]  seq
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {IDLE, SEND, WAIT} state_t;

    state_t      state_q, state_d;
    logic [31:0] mem_q [FIFO_DEPTH];
    logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [CW-1:0] count_q, count_d;
    logic [31:0] data_q, data_d;
    logic [2:0]  idx_q, idx_d;
    logic [7:0]  seq_q, seq_d;
    logic [7:0]  tx_byte_q, tx_byte_d;
    logic        push, pop;

    // Byte i of the frame; the checksum covers everything but the sync byte
    function automatic logic [7:0] frame_byte(input logic [2:0] i, input logic [31:0] d, input logic [7:0] s);
        case (i)
            3'd0:    frame_byte = SYNC_BYTE;
            3'd1:    frame_byte = s;
            3'd2:    frame_byte = d[7:0];
            3'd3:    frame_byte = d[15:8];
            3'd4:    frame_byte = d[23:16];
            3'd5:    frame_byte = d[31:24];
            default: frame_byte = s ^ d[7:0] ^ d[15:8] ^ d[23:16] ^ d[31:24];
        endcase
    endfunction

    assign res_ready = count_q != CW'(FIFO_DEPTH);
    assign push      = res_valid && res_ready;
    assign pop       = (state_q == IDLE) && (count_q != '0);
    assign tx_send   = state_q == SEND;
    assign tx_byte   = tx_byte_q;
    assign seq       = seq_q;
    assign busy      = (state_q != IDLE) || (count_q != '0);

    // FIFO pointer and occupancy bookkeeping; push and pop may coincide
    always_comb begin
        wr_d    = wr_q + AW'(push);
        rd_d    = rd_q + AW'(pop);
        count_d = count_q + CW'(push) - CW'(pop);
    end

    // FIFO storage needs no reset: occupancy alone decides what is valid
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_q] <= res_data;
    end

    // Frame sequencer: pop, then alternate one-cycle send strobe and wait-for-done per byte
    always_comb begin
        state_d   = state_q;
        data_d    = data_q;
        idx_d     = idx_q;
        seq_d     = seq_q;
        tx_byte_d = tx_byte_q;
        case (state_q)
            IDLE: if (pop) begin
                data_d    = mem_q[rd_q];
                idx_d     = 3'd0;
                tx_byte_d = SYNC_BYTE;
                state_d   = SEND;
            end
            SEND: state_d = WAIT;
            WAIT: if (tx_done) begin
                if (idx_q == 3'd6) begin
                    seq_d   = seq_q + 8'd1;
                    state_d = IDLE;
                end else begin
                    idx_d     = idx_q + 3'd1;
                    tx_byte_d = frame_byte(idx_q + 3'd1, data_q, seq_q);
                    state_d   = SEND;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State registers; reset aborts any frame in flight and empties the FIFO
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            wr_q      <= '0;
            rd_q      <= '0;
            count_q   <= '0;
            data_q    <= '0;
            idx_q     <= '0;
            seq_q     <= '0;
            tx_byte_q <= '0;
        end else begin
            state_q   <= state_d;
            wr_q      <= wr_d;
            rd_q      <= rd_d;
            count_q   <= count_d;
            data_q    <= data_d;
            idx_q     <= idx_d;
            seq_q     <= seq_d;
            tx_byte_q <= tx_byte_d;
        end
    end
endmodule

// File: tb/tb_sa_result_uart_framer.sv
// tb_sa_result_uart_framer: scoreboard bench with a UART done-pulse model and a byte monitor
module tb_sa_result_uart_framer;
    logic        clk = 1'b0;
    logic        reset;
    logic        res_valid;
    logic [31:0] res_data;
    logic        res_ready;
    logic [7:0]  tx_byte;
    logic        tx_send;
    logic        tx_done;
    logic        busy;
    logic [7:0]  seq;

    logic        model_done = 1'b0;
    logic        glitch = 1'b0;
    logic        hold = 1'b0;
    logic        pending = 1'b0;
    int          cnt = 0;

    logic [7:0]  exp_q [$];
    int          total = 0;
    int          passed = 0;
    int          nsent = 0;
    logic        prev_send = 1'b0;
    logic [7:0]  sent_byte = 8'h00;

    assign tx_done = model_done | glitch;

    sa_result_uart_framer #(.FIFO_DEPTH(4), .SYNC_BYTE(8'hA5)) dut (
        .clk(clk), .reset(reset), .res_valid(res_valid), .res_data(res_data),
        .res_ready(res_ready), .tx_byte(tx_byte), .tx_send(tx_send),
        .tx_done(tx_done), .busy(busy), .seq(seq)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    task automatic exp56(input logic [55:0] f);
        for (int i = 0; i < 7; i++) exp_q.push_back(f[55-8*i -: 8]);
    endtask

    task automatic exp_frame(input logic [7:0] s, input logic [31:0] d);
        exp56({8'hA5, s, d[7:0], d[15:8], d[23:16], d[31:24], s ^ d[7:0] ^ d[15:8] ^ d[23:16] ^ d[31:24]});
    endtask

    task automatic push_word(input logic [31:0] d);
        @(negedge clk);
        chk("push_ready", res_ready, 1);
        res_valid = 1'b1;
        res_data  = d;
        @(negedge clk);
        res_valid = 1'b0;
    endtask

    task automatic drain(input string nm);
        int n = 0;
        while ((exp_q.size() != 0 || busy) && n < 2000) begin
            @(negedge clk);
            n++;
        end
        chk({nm, "_left"}, exp_q.size(), 0);
        chk({nm, "_busy"}, busy, 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
    endtask

    // UART model: done pulse 10 cycles after each send, frozen while hold is set
    always @(negedge clk) begin
        model_done = 1'b0;
        if (!reset) begin
            pending = 1'b0;
        end else if (tx_send) begin
            pending = 1'b1;
            cnt = 10;
        end else if (pending && !hold) begin
            if (cnt > 1) cnt--;
            else begin
                model_done = 1'b1;
                pending = 1'b0;
            end
        end
    end

    // Monitor: every send strobe is compared against the next expected byte
    always @(negedge clk) begin
        if (tx_send) begin
            if (prev_send) begin
                total++;
                $display("FAIL send_back_to_back: tx_send high two cycles running");
            end
            if (exp_q.size() == 0) begin
                total++;
                $display("FAIL unexpected_send: got byte %0h with nothing expected", tx_byte);
            end else chk("byte", tx_byte, exp_q.pop_front());
            sent_byte = tx_byte;
            nsent++;
        end else if (tx_done && reset) chk("byte_hold", tx_byte, sent_byte);
        prev_send = tx_send;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not complete, %0d/%0d checks so far", passed, total);
        $fatal(1, "watchdog");
    end

    initial begin
        int acc;
        int n;
        int base;
        reset = 1'b1;
        res_valid = 1'b0;
        res_data = '0;
        #2 reset = 1'b0;
        #1;
        chk("rst_send", tx_send, 0);
        chk("rst_byte", tx_byte, 0);
        chk("rst_seq", seq, 0);
        chk("rst_busy", busy, 0);
        chk("rst_ready", res_ready, 1);
        repeat (3) @(negedge clk);
        reset = 1'b1;

        exp56(56'hA5_00_78_56_34_12_08);
        push_word(32'h12345678);
        chk("lat_n", tx_send, 0);
        chk("lat_busy", busy, 1);
        @(negedge clk);
        chk("lat_n1", tx_send, 1);
        drain("w1");
        chk("w1_seq", seq, 1);

        exp56(56'hA5_01_FF_FF_FF_FF_01);
        push_word(32'hFFFFFFFF);
        drain("w2");
        chk("w2_seq", seq, 2);

        @(negedge clk);
        glitch = 1'b1;
        @(negedge clk);
        glitch = 1'b0;
        chk("glitch_idle_seq", seq, 2);
        chk("glitch_idle_busy", busy, 0);
        exp56(56'hA5_02_0D_F0_FE_CA_CB);
        push_word(32'hCAFEF00D);
        n = 0;
        while (!tx_send && n < 50) begin
            @(negedge clk);
            #1 n++;
        end
        chk("glitch_send_seen", tx_send, 1);
        glitch = 1'b1;
        @(negedge clk);
        glitch = 1'b0;
        drain("glitch");
        chk("glitch_seq", seq, 3);

        do_reset();
        hold = 1'b1;
        acc = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            res_valid = 1'b1;
            res_data  = 32'hC0DE0000 | acc;
            chk("cap_ready", res_ready, (c < 5) ? 1 : 0);
            if (res_ready) begin
                exp_frame(acc[7:0], 32'hC0DE0000 | acc);
                acc++;
            end
        end
        @(negedge clk);
        res_valid = 1'b0;
        chk("cap_accepted", acc, 5);
        hold = 1'b0;
        drain("cap");
        chk("cap_seq", seq, 5);

        base = nsent;
        exp56(56'hA5_05_DD_CC_00_00_00);
        repeat (3) void'(exp_q.pop_back());
        push_word(32'hAABBCCDD);
        push_word(32'h11223344);
        n = 0;
        while (nsent < base + 4 && n < 500) begin
            @(negedge clk);
            #1 n++;
        end
        chk("mid_sent", nsent - base, 4);
        reset = 1'b0;
        #1;
        chk("mid_send", tx_send, 0);
        chk("mid_byte", tx_byte, 0);
        chk("mid_seq", seq, 0);
        chk("mid_busy", busy, 0);
        chk("mid_ready", res_ready, 1);
        chk("mid_left", exp_q.size(), 0);
        repeat (5) @(negedge clk);
        reset = 1'b1;
        base = nsent;
        repeat (30) @(negedge clk);
        chk("mid_quiet", nsent - base, 0);
        exp56(56'hA5_00_01_00_00_00_01);
        push_word(32'h00000001);
        drain("post");
        chk("post_seq", seq, 1);

        do_reset();
        for (int k = 0; k < 257; k++) begin
            if (k == 255) exp56(56'hA5_FF_00_00_00_00_FF);
            else if (k == 256) exp56(56'hA5_00_00_00_00_00_00);
            else exp_frame(k[7:0], 32'h0);
            push_word(32'h0);
            drain("wrap");
        end
        chk("wrap_seq", seq, 1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
